// File: rtl/iic_pkg.sv
// Shared I2C controller types and constants.
// Used by the register write controller and the read controller.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FINISH,
    ST_FAIL
  } iic_state_e;

  localparam int   IIC_BYTES_PER_WR  = 3;
  localparam logic IIC_WRITE_BIT     = 1'b0;
  localparam int   IIC_DEF_TIMEOUT   = 2000;
  localparam int   IIC_DEF_GAP       = 10;
  localparam int   IIC_DEF_MAX_RETRY = 3;

  function automatic logic [7:0] iic_byte_sel(
    input logic [1:0] idx,
    input logic [6:0] dev,
    input logic [7:0] ra,
    input logic [7:0] wd
  );
    logic [7:0] b;
    b = wd;
    unique case (1'b1)
      (idx == 2'd0): b = {dev, IIC_WRITE_BIT};
      (idx == 2'd1): b = ra;
      default:       b = wd;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iic_cycle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
// Shared by the byte timeout and the inter-byte gap.
module iic_cycle_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/iic_reg_write_ctrl.sv
// Sequences dev-addr/reg-addr/data bytes through the I2C byte writer
// with inter-byte gap, per-byte timeout and whole-transaction retry.
module iic_reg_write_ctrl
  import iic_pkg::*;
#(
  parameter int TIMEOUT   = IIC_DEF_TIMEOUT,
  parameter int GAP       = IIC_DEF_GAP,
  parameter int MAX_RETRY = IIC_DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       ok,
  output logic       err,
  output logic       bw_en,
  output logic [7:0] bw_data,
  input  logic       bw_done
);

  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] TO_LD   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
  localparam logic [1:0]    LAST_IX = 2'(IIC_BYTES_PER_WR - 1);
  localparam logic [RW-1:0] RT_MAX  = RW'(MAX_RETRY);

  iic_state_e    state_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    dat_q;
  logic [1:0]    idx_q;
  logic [RW-1:0] retry_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_exp;

  // Timer reloads on issue (timeout) and on every exit from WAIT (gap).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = GAP_LD;
    if (state_q == ST_ISSUE) begin
      tmr_load = 1'b1;
      tmr_val  = TO_LD;
    end else if (state_q == ST_WAIT && (bw_done || tmr_exp)) begin
      tmr_load = 1'b1;
    end
  end

  iic_cycle_timer #(
    .W(CW)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      busy    <= 1'b0;
      ok      <= 1'b0;
      err     <= 1'b0;
      bw_en   <= 1'b0;
      bw_data <= '0;
    end else begin
      bw_en <= 1'b0;
      ok    <= 1'b0;
      err   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            dat_q   <= wr_data;
            idx_q   <= '0;
            retry_q <= '0;
            busy    <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bw_en   <= 1'b1;
          bw_data <= iic_byte_sel(idx_q, dev_q, reg_q, dat_q);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bw_done) begin
            if (idx_q == LAST_IX) begin
              ok      <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= ST_GAP;
            end
          end else if (tmr_exp) begin
            if (retry_q < RT_MAX) begin
              retry_q <= retry_q + RW'(1);
              idx_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              err     <= 1'b1;
              state_q <= ST_FAIL;
            end
          end
        end
        ST_GAP: begin
          if (tmr_exp) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_FINISH, ST_FAIL: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
